// File: rtl/shs_pkg.sv
// Shared constants and types for the home-automation sensor front end.
package shs_pkg;

  localparam int unsigned TEMP_W = 8;

  // Controller thresholds in degrees C: fan on above FAN, AC on above AC.
  localparam int unsigned FAN_THRESH = 25;
  localparam int unsigned AC_THRESH  = 28;

  localparam int unsigned NUM_SENS    = 5;
  localparam int unsigned SENS_LIGHT  = 0;
  localparam int unsigned SENS_MOTION = 1;
  localparam int unsigned SENS_GAS    = 2;
  localparam int unsigned SENS_DOOR   = 3;
  localparam int unsigned SENS_RAIN   = 4;

  // Light idles "bright" so the controller keeps the lamp off out of reset.
  localparam logic [NUM_SENS-1:0] SENS_RESET_VAL = 5'b00001;

  typedef enum logic {
    FILL,
    RUN
  } temp_state_e;

endpackage

// File: rtl/sensor_conditioner_if.sv
// Sensor-side bundle between the raw sensor lines and the controller inputs.
interface sensor_conditioner_if #(
  parameter int unsigned TEMP_W = shs_pkg::TEMP_W
);
  logic              sample_tick;
  logic [TEMP_W-1:0] temp_raw;
  logic              light_raw;
  logic              motion_raw;
  logic              gas_raw;
  logic              door_raw;
  logic              rain_raw;

  logic [TEMP_W-1:0] temperature;
  logic              temp_valid;
  logic              light_sensor;
  logic              motion_sensor;
  logic              gas_sensor;
  logic              door_sensor;
  logic              rain_sensor;
  logic              sensor_change;

  modport master (
    output sample_tick, temp_raw, light_raw, motion_raw, gas_raw, door_raw, rain_raw,
    input  temperature, temp_valid, light_sensor, motion_sensor, gas_sensor, door_sensor,
           rain_sensor, sensor_change
  );

  modport slave (
    input  sample_tick, temp_raw, light_raw, motion_raw, gas_raw, door_raw, rain_raw,
    output temperature, temp_valid, light_sensor, motion_sensor, gas_sensor, door_sensor,
           rain_sensor, sensor_change
  );
endinterface

// File: rtl/debounce_bit.sv
// Two-flop synchroniser followed by a saturating-run debounce counter.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic flip
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchroniser, counter and output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
      level_q <= RESET_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count consecutive disagreeing cycles; any agreement restarts the run.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign level = level_q;
  assign flip  = (level_d != level_q);

endmodule

// File: rtl/sensor_conditioner.sv
// Debounces the binary room sensors and moving-averages the temperature.
module sensor_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TEMP_W          = shs_pkg::TEMP_W,
  parameter int unsigned AVG_LOG2        = 2
) (
  input logic                 clk,
  input logic                 reset,
  sensor_conditioner_if.slave bus
);
  import shs_pkg::*;

  localparam int unsigned N     = 1 << AVG_LOG2;
  localparam int unsigned SUM_W = TEMP_W + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] PTR_LAST = AVG_LOG2'(N - 1);

  logic [NUM_SENS-1:0] raw_vec, level_vec, flip_vec;
  logic                change_q;

  assign raw_vec[SENS_LIGHT]  = bus.light_raw;
  assign raw_vec[SENS_MOTION] = bus.motion_raw;
  assign raw_vec[SENS_GAS]    = bus.gas_raw;
  assign raw_vec[SENS_DOOR]   = bus.door_raw;
  assign raw_vec[SENS_RAIN]   = bus.rain_raw;

  for (genvar i = 0; i < NUM_SENS; i++) begin : g_sens
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (SENS_RESET_VAL[i])
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_vec[i]),
      .level(level_vec[i]),
      .flip (flip_vec[i])
    );
  end

  // Registered so the pulse lines up with the cycle the new level is visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) change_q <= 1'b0;
    else       change_q <= |flip_vec;
  end

  assign bus.light_sensor  = level_vec[SENS_LIGHT];
  assign bus.motion_sensor = level_vec[SENS_MOTION];
  assign bus.gas_sensor    = level_vec[SENS_GAS];
  assign bus.door_sensor   = level_vec[SENS_DOOR];
  assign bus.rain_sensor   = level_vec[SENS_RAIN];
  assign bus.sensor_change = change_q;

  temp_state_e         state_q, state_d;
  logic [TEMP_W-1:0]   ring_q [N];
  logic [SUM_W-1:0]    sum_q, sum_d, sum_new;
  logic [AVG_LOG2-1:0] ptr_q, ptr_d;
  logic [TEMP_W-1:0]   temp_q, temp_d;
  logic                valid_q, valid_d;

  // Averaging state, ring buffer and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      sum_q   <= '0;
      ptr_q   <= '0;
      temp_q  <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < int'(N); i++) ring_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      ptr_q   <= ptr_d;
      temp_q  <= temp_d;
      valid_q <= valid_d;
      if (bus.sample_tick) ring_q[ptr_q] <= bus.temp_raw;
    end
  end

  // Fill the window first, then slide it: the pointer always names the oldest entry.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    ptr_d   = ptr_q;
    temp_d  = temp_q;
    valid_d = valid_q;
    sum_new = sum_q + SUM_W'(bus.temp_raw);
    if (state_q == RUN) sum_new = sum_new - SUM_W'(ring_q[ptr_q]);
    unique case (state_q)
      FILL: begin
        if (bus.sample_tick) begin
          sum_d = sum_new;
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == PTR_LAST) begin
            temp_d  = TEMP_W'(sum_new >> AVG_LOG2);
            valid_d = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (bus.sample_tick) begin
          sum_d  = sum_new;
          ptr_d  = ptr_q + 1'b1;
          temp_d = TEMP_W'(sum_new >> AVG_LOG2);
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign bus.temperature = temp_q;
  assign bus.temp_valid  = valid_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Self-checking bench for sensor_conditioner: debounce timing and moving average.
module tb_sensor_conditioner;

  typedef struct packed {
    logic [7:0] t;
    logic       v;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  sensor_conditioner_if bus ();

  sensor_conditioner #(
    .DEBOUNCE_CYCLES(16),
    .TEMP_W         (8),
    .AVG_LOG2       (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic idle_inputs;
    bus.sample_tick = 1'b0;
    bus.temp_raw    = 8'd0;
    bus.light_raw   = 1'b1;
    bus.motion_raw  = 1'b0;
    bus.gas_raw     = 1'b0;
    bus.door_raw    = 1'b0;
    bus.rain_raw    = 1'b0;
  endtask

  task automatic apply_reset;
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive one sample and queue the output expected on the following cycle.
  task automatic send_tick(input logic [7:0] v, input logic [7:0] et, input logic ev);
    exp_t e;
    e.t = et;
    e.v = ev;
    exp_q.push_back(e);
    @(negedge clk);
    bus.sample_tick = 1'b1;
    bus.temp_raw    = v;
    @(posedge clk);
    #1;
    bus.sample_tick = 1'b0;
  endtask

  task automatic test_reset;
    logic [14:0] got;
    apply_reset();
    got = {bus.light_sensor, bus.motion_sensor, bus.gas_sensor, bus.door_sensor,
           bus.rain_sensor, bus.sensor_change, bus.temp_valid, bus.temperature};
    n_cmp++;
    if (got !== 15'b100000000000000) begin
      n_bad++;
      $display("FAIL reset_values: got %b expected %b", got, 15'b100000000000000);
    end
  endtask

  task automatic test_motion;
    int rise_k = 0, fall_k = 0, pulses = 0, pulse_k = 0;
    @(negedge clk);
    bus.motion_raw = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      if (bus.motion_sensor === 1'b1 && rise_k == 0) rise_k = k;
      if (bus.sensor_change === 1'b1) begin pulses++; pulse_k = k; end
    end
    n_cmp++;
    if (rise_k != 18) begin n_bad++; $display("FAIL motion_rise: got %0d expected 18", rise_k); end
    n_cmp++;
    if (pulses != 1 || pulse_k != 18) begin
      n_bad++;
      $display("FAIL motion_pulse: got %0d pulses at %0d expected 1 at 18", pulses, pulse_k);
    end
    @(negedge clk);
    bus.motion_raw = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      if (bus.motion_sensor === 1'b0 && fall_k == 0) fall_k = k;
    end
    n_cmp++;
    if (fall_k != 18) begin n_bad++; $display("FAIL motion_fall: got %0d expected 18", fall_k); end
  endtask

  task automatic test_gas;
    int rise_k, fall_k, pulses;
    // A 15-cycle glitch must vanish entirely.
    pulses = 0; rise_k = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk); bus.gas_raw = (k <= 15);
      @(posedge clk); #1;
      if (bus.gas_sensor === 1'b1 && rise_k == 0) rise_k = k;
      if (bus.sensor_change === 1'b1) pulses++;
    end
    n_cmp++;
    if (rise_k != 0 || pulses != 0) begin
      n_bad++;
      $display("FAIL gas_reject15: got rise %0d pulses %0d expected 0 and 0", rise_k, pulses);
    end
    // 16 cycles is just enough; release then takes 16 more synced cycles.
    pulses = 0; rise_k = 0; fall_k = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk); bus.gas_raw = (k <= 16);
      @(posedge clk); #1;
      if (bus.gas_sensor === 1'b1 && rise_k == 0) rise_k = k;
      if (bus.gas_sensor === 1'b0 && rise_k != 0 && fall_k == 0) fall_k = k;
      if (bus.sensor_change === 1'b1) pulses++;
    end
    n_cmp++;
    if (rise_k != 18) begin n_bad++; $display("FAIL gas_accept16: got %0d expected 18", rise_k); end
    n_cmp++;
    if (fall_k != 34 || pulses != 2) begin
      n_bad++;
      $display("FAIL gas_release: got fall %0d pulses %0d expected 34 and 2", fall_k, pulses);
    end
  endtask

  task automatic test_simultaneous;
    int door_k = 0, rain_k = 0, pulses = 0;
    @(negedge clk);
    bus.door_raw = 1'b1;
    bus.rain_raw = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      if (bus.door_sensor === 1'b1 && door_k == 0) door_k = k;
      if (bus.rain_sensor === 1'b1 && rain_k == 0) rain_k = k;
      if (bus.sensor_change === 1'b1) pulses++;
    end
    n_cmp++;
    if (door_k != 18 || rain_k != 18) begin
      n_bad++;
      $display("FAIL two_flip_time: got door %0d rain %0d expected 18 and 18", door_k, rain_k);
    end
    n_cmp++;
    if (pulses != 1) begin n_bad++; $display("FAIL two_flip_pulse: got %0d expected 1", pulses); end
    @(negedge clk);
    bus.door_raw = 1'b0;
    bus.rain_raw = 1'b0;
    repeat (25) @(posedge clk);
  endtask

  task automatic test_temp_avg;
    logic [7:0] vals [9] = '{8'd20, 8'd24, 8'd28, 8'd32, 8'd36, 8'd255, 8'd255, 8'd255, 8'd255};
    logic [7:0] exps [9] = '{8'd0, 8'd0, 8'd0, 8'd26, 8'd30, 8'd87, 8'd144, 8'd200, 8'd255};
    logic       expv [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] tv   [4] = '{8'd1, 8'd1, 8'd1, 8'd2};
    exp_t e;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      send_tick(vals[i], exps[i], expv[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.temperature !== e.t || bus.temp_valid !== e.v) begin
        n_bad++;
        $display("FAIL temp_avg[%0d]: got temp=%0d valid=%b expected temp=%0d valid=%b",
                 i, bus.temperature, bus.temp_valid, e.t, e.v);
      end
      // Hold check after the first sliding update.
      if (i == 4) begin
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.temperature !== 8'd30 || bus.temp_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL temp_hold: got temp=%0d valid=%b expected 30 1",
                   bus.temperature, bus.temp_valid);
        end
      end
    end
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      send_tick(tv[i], (i == 3) ? 8'd1 : 8'd0, (i == 3));
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.temperature !== e.t || bus.temp_valid !== e.v) begin
        n_bad++;
        $display("FAIL temp_trunc[%0d]: got temp=%0d valid=%b expected temp=%0d valid=%b",
                 i, bus.temperature, bus.temp_valid, e.t, e.v);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [14:0] got;
    bus.light_raw  = 1'b0;
    bus.motion_raw = 1'b1;
    repeat (22) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.light_sensor !== 1'b0 || bus.motion_sensor !== 1'b1 || bus.temp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_state: got light=%b motion=%b valid=%b expected 0 1 1",
               bus.light_sensor, bus.motion_sensor, bus.temp_valid);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    got = {bus.light_sensor, bus.motion_sensor, bus.gas_sensor, bus.door_sensor,
           bus.rain_sensor, bus.sensor_change, bus.temp_valid, bus.temperature};
    n_cmp++;
    if (got !== 15'b100000000000000) begin
      n_bad++;
      $display("FAIL async_reset: got %b expected %b", got, 15'b100000000000000);
    end
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_fill;
    exp_t e;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      send_tick(8'd40, 8'd0, 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.temperature !== e.t || bus.temp_valid !== e.v) begin
        n_bad++;
        $display("FAIL pre_reset_fill[%0d]: got temp=%0d valid=%b expected temp=%0d valid=%b",
                 i, bus.temperature, bus.temp_valid, e.t, e.v);
      end
    end
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      send_tick(8'd10, (i == 3) ? 8'd10 : 8'd0, (i == 3));
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.temperature !== e.t || bus.temp_valid !== e.v) begin
        n_bad++;
        $display("FAIL refill[%0d]: got temp=%0d valid=%b expected temp=%0d valid=%b",
                 i, bus.temperature, bus.temp_valid, e.t, e.v);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_motion();
    test_gas();
    test_simultaneous();
    test_temp_avg();
    test_async_reset();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
